// File: rtl/x7seg_pkg.sv
// x7seg_pkg: shared constants for the multiplexed 7-segment display driver.
//  - SEG_TAB  : 16-entry hex -> segment table, active-low, bit order [6]=a..[0]=g
//  - SEG_OFF  : all segments dark
//  - *_DEF    : default geometry/timing for top-level wrappers
//  - phase_t  : scan phase within one digit slot
package x7seg_pkg;

  localparam int NDIG_DEF      = 4;
  localparam int DIG_CYC_DEF   = 50000;  // 1 ms per digit at 50 MHz
  localparam int BLANK_CYC_DEF = 1000;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  typedef enum logic {
    PH_ON    = 1'b0,
    PH_BLANK = 1'b1
  } phase_t;

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex digit -> 7-segment pattern (active-low, abcdefg).
//  nib  in  4  hex value
//  seg  out 7  segment pattern, [6]=a .. [0]=g, 0 = lit
module hex7seg
  import x7seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TAB[nib];

endmodule

// File: rtl/x7seg_scan.sv
// x7seg_scan: time-multiplexed driver for a common-anode NDIG-digit display.
//  Each digit owns a slot of DIG_CYC cycles; the last BLANK_CYC cycles of every
//  slot drive all anodes off to avoid ghosting. New values land in a shadow
//  buffer and are copied to the display register only at the frame wrap, so a
//  frame is never drawn from two different values.
//  Ports:
//   clk        in   1        rising-edge clock
//   clr_n      in   1        async active-low reset
//   x          in   4*NDIG   value to show, nibble i -> digit i
//   dp_in      in   NDIG     decimal point request per digit, active-high
//   x_valid    in   1        strobe: capture x/dp_in into shadow
//   lzb_en     in   1        leading-zero blanking enable
//   a_to_g     out  7        segments, active-low, [6]=a .. [0]=g
//   dp         out  1        decimal point, active-low
//   an         out  NDIG     anodes, active-low, at most one low
//   frame_tick out  1        one-cycle pulse after the last slot of a frame
module x7seg_scan
  import x7seg_pkg::*;
#(
  parameter int NDIG      = NDIG_DEF,
  parameter int DIG_CYC   = DIG_CYC_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic [4*NDIG-1:0]   x,
  input  logic [NDIG-1:0]     dp_in,
  input  logic                x_valid,
  input  logic                lzb_en,
  output logic [6:0]          a_to_g,
  output logic                dp,
  output logic [NDIG-1:0]     an,
  output logic                frame_tick
);

  localparam int CW = $clog2(DIG_CYC);
  localparam int DW = $clog2(NDIG);

  localparam logic [CW-1:0] CNT_LAST    = CW'(DIG_CYC - 1);
  localparam logic [CW-1:0] CNT_ON_LAST = CW'(DIG_CYC - BLANK_CYC - 1);
  localparam logic [DW-1:0] DIG_LAST    = DW'(NDIG - 1);

  logic [CW-1:0]       cnt;
  logic [DW-1:0]       dig;
  phase_t              state_q, state_d;

  logic [4*NDIG-1:0]   shadow, disp;
  logic [NDIG-1:0]     shadow_dp, disp_dp;
  logic                pend;

  logic                slot_end, wrap;
  logic [NDIG-1:0]     hz;        // nibbles NDIG-1..i of disp all zero
  logic [NDIG-1:0]     lz;        // digit suppressed by leading-zero blanking
  logic [NDIG-1:0][6:0] seg_all;

  logic                lit;
  logic [NDIG-1:0]     an_d;
  logic [6:0]          seg_d;
  logic                dp_d;

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = slot_end && (dig == DIG_LAST);

  // ---------------------------------------------------------------- scan counters
  // dig wraps explicitly so non-power-of-2 digit counts never index a missing digit.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
      dig <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      dig <= (dig == DIG_LAST) ? '0 : dig + DW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------- phase FSM
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= PH_ON;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_ON:    if (cnt == CNT_ON_LAST) state_d = PH_BLANK;
      PH_BLANK: if (slot_end)           state_d = PH_ON;
      default:                          state_d = PH_ON;
    endcase
  end

  // ---------------------------------------------------------------- double buffer
  // A strobe on the wrap cycle goes straight to disp so it shows this frame;
  // the trailing pend<=0 overrides the strobe's own pend<=1.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shadow    <= '0;
      shadow_dp <= '0;
      pend      <= 1'b0;
      disp      <= '0;
      disp_dp   <= '0;
    end else begin
      if (x_valid) begin
        shadow    <= x;
        shadow_dp <= dp_in;
        pend      <= 1'b1;
      end
      if (wrap) begin
        if (pend || x_valid) begin
          disp    <= x_valid ? x     : shadow;
          disp_dp <= x_valid ? dp_in : shadow_dp;
        end
        pend <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- per-digit decode
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign hz[g] = (disp[4*NDIG-1:4*g] == '0);
    if (g == 0) begin : g_lsd
      assign lz[g] = 1'b0;  // the units digit always shows, even for zero
    end else begin : g_msd
      assign lz[g] = lzb_en && hz[g];
    end
    hex7seg u_dec (
      .nib (disp[4*g +: 4]),
      .seg (seg_all[g])
    );
  end

  // ---------------------------------------------------------------- output stage
  always_comb begin
    lit = (state_q == PH_ON) && !lz[dig];
    for (int i = 0; i < NDIG; i++) begin
      an_d[i] = ~(lit && (dig == DW'(i)));
    end
    seg_d = lit ? seg_all[dig] : SEG_OFF;
    dp_d  = lit ? ~disp_dp[dig] : 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      an         <= '1;
      a_to_g     <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      a_to_g     <= seg_d;
      dp         <= dp_d;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_x7seg_scan.sv
// tb_x7seg_scan: directed scoreboard bench for x7seg_scan (NDIG=4, DIG_CYC=8,
// BLANK_CYC=2). Stimulus pushes one expected pin state per cycle; a monitor on
// the falling edge pops and compares.
module tb_x7seg_scan;

  localparam int NDIG = 4, DIG_CYC = 8, BLANK_CYC = 2, FRAME = 32;

  logic        clk = 1'b0, clr_n = 1'b0;
  logic [15:0] x = '0;
  logic [3:0]  dp_in = '0;
  logic        x_valid = 1'b0, lzb_en = 1'b0;
  logic [6:0]  a_to_g;
  logic        dp, frame_tick;
  logic [3:0]  an;

  x7seg_scan #(.NDIG(NDIG), .DIG_CYC(DIG_CYC), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .clr_n(clr_n), .x(x), .dp_in(dp_in), .x_valid(x_valid),
    .lzb_en(lzb_en), .a_to_g(a_to_g), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    int         frm;
    int         slot;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0, frm_no = 0;
  exp_t e;

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({an, a_to_g, dp, frame_tick} !== {e.an, e.seg, e.dp, e.tick}) begin
        failures++;
        $display("FAIL scan f%0d s%0d: got an=%b seg=%b dp=%b tick=%b, want an=%b seg=%b dp=%b tick=%b",
                 e.frm, e.slot, an, a_to_g, dp, frame_tick, e.an, e.seg, e.dp, e.tick);
      end
    end
  end

  task automatic push_off(input int slot);
    q.push_back('{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0, frm: frm_no, slot: slot});
  endtask

  // Hold reset across four edges (outputs must stay dark), then release.
  task automatic release_rst();
    for (int k = 0; k < 4; k++) push_off(-1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    clr_n = 1'b1;
  endtask

  // Inputs sampled by the edge that produces slot s.
  task automatic set_in(input int s, input int sa, input logic [15:0] xa, input logic [3:0] da,
                        input int sb, input logic [15:0] xb, input logic [3:0] db);
    x_valid = 1'b0;
    if (s == sa) begin x_valid = 1'b1; x = xa; dp_in = da; end
    if (s == sb) begin x_valid = 1'b1; x = xb; dp_in = db; end
  endtask

  // One 32-cycle frame. s3..s0: expected segment patterns; dpm: lit decimal
  // points; blk: digits expected dark for the whole slot; rst_at: slot at which
  // reset is asserted (-1 = none).
  task automatic frame(input logic [6:0] s3, s2, s1, s0, input logic [3:0] dpm, blk,
                       input logic lz, input int sa, input logic [15:0] xa, input logic [3:0] da,
                       input int sb, input logic [15:0] xb, input logic [3:0] db,
                       input int rst_at);
    logic [6:0] segs [4];
    logic [3:0] one;
    exp_t       ex;
    int         d, c;
    logic       on;
    segs = '{s0, s1, s2, s3};
    one  = 4'b0001;
    frm_no++;
    for (int j = 0; j < FRAME; j++) begin
      if (rst_at >= 0 && j >= rst_at) begin
        if (j == rst_at) push_off(j);
      end else begin
        d  = j / DIG_CYC;
        c  = j % DIG_CYC;
        on = (c < DIG_CYC - BLANK_CYC) && !blk[d];
        ex.an   = on ? ~(one << d) : 4'hF;
        ex.seg  = on ? segs[d] : 7'h7F;
        ex.dp   = on ? ~dpm[d] : 1'b1;
        ex.tick = (j == FRAME - 1);
        ex.frm  = frm_no;
        ex.slot = j;
        q.push_back(ex);
      end
    end
    lzb_en = lz;
    set_in(0, sa, xa, da, sb, xb, db);
    for (int j = 0; j < FRAME; j++) begin
      @(posedge clk); #1;
      if (j == rst_at) begin
        clr_n   = 1'b0;
        x_valid = 1'b0;
        return;
      end
      if (j < FRAME - 1) set_in(j + 1, sa, xa, da, sb, xb, db);
      else               x_valid = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    release_rst();
    // Power-up: all zeros; strobe 00A5 mid-frame, must not show yet.
    frame(7'h01, 7'h01, 7'h01, 7'h01, 4'h0, 4'h0, 1'b0, 10, 16'h00A5, 4'h0, -1, 16'h0, 4'h0, -1);
    // 00A5 now visible.
    frame(7'h01, 7'h01, 7'h08, 7'h24, 4'h0, 4'h0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, -1);
    // Leading-zero blanking hides digits 3,2; two strobes, last one (BEEF) wins.
    frame(7'h01, 7'h01, 7'h08, 7'h24, 4'h0, 4'b1100, 1'b1, 3, 16'h1234, 4'h0, 20, 16'hBEEF, 4'h0, -1);
    // BEEF; strobe 0007 on the exact wrap cycle.
    frame(7'h60, 7'h30, 7'h30, 7'h38, 4'h0, 4'h0, 1'b0, 31, 16'h0007, 4'h0, -1, 16'h0, 4'h0, -1);
    // 0007 without extra frame delay; strobe 3C90 with dp on digit 2.
    frame(7'h01, 7'h01, 7'h01, 7'h0F, 4'h0, 4'h0, 1'b0, 12, 16'h3C90, 4'b0100, -1, 16'h0, 4'h0, -1);
    // 3C90 with dp on digit 2; a pending strobe, then reset mid digit-2 ON.
    frame(7'h06, 7'h31, 7'h04, 7'h01, 4'b0100, 4'h0, 1'b0, 5, 16'h1111, 4'hF, -1, 16'h0, 4'h0, 20);
    release_rst();
    // After reset: disp cleared, pending update lost, scan from digit 0.
    frame(7'h01, 7'h01, 7'h01, 7'h01, 4'h0, 4'h0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, -1);
    // All-zero with blanking: only digit 0 lights.
    frame(7'h01, 7'h01, 7'h01, 7'h01, 4'h0, 4'b1110, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0, -1);

    for (int k = 0; k < 100 && q.size() > 0; k++) begin
      @(negedge clk); #1;
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
